// File: rtl/pht_update_queue_pkg.sv
// Shared fetch-unit types: PHT update entry layout, queue pointer width and
// the saturating counter step used by both the predictor and its update queue.
package FetchUnitTypes;

  localparam int unsigned PHT_UPDATE_QUEUE_SIZE = 8;
  localparam int unsigned PHT_INDEX_WIDTH       = 10;
  localparam int unsigned PHT_CTR_WIDTH         = 2;

  typedef logic [$clog2(PHT_UPDATE_QUEUE_SIZE)-1:0] PhtUpdateQueuePointerPath;

  typedef struct packed {
    logic [PHT_INDEX_WIDTH-1:0] index;
    logic [PHT_CTR_WIDTH-1:0]   ctr;
  } PhtUpdateEntry;

  // Counter widths up to 8 bits; callers pass their own saturation limit.
  function automatic logic [7:0] step(input logic [7:0] c, input logic t,
                                      input logic [7:0] ctrMax);
    if (t) return (c == ctrMax) ? ctrMax : c + 8'd1;
    else   return (c == '0) ? '0 : c - 8'd1;
  endfunction

endpackage

// File: rtl/pht_update_queue_pointer.sv
// Circular head/tail/occupancy tracker with multi-entry push and single pop.
module QueuePointer #(
  parameter int unsigned SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SIZE):0]    pushCount,
  input  logic                     pop,
  output logic [$clog2(SIZE)-1:0]  headPtr,
  output logic [$clog2(SIZE)-1:0]  tailPtr,
  output logic [$clog2(SIZE)-1:0]  headNext,
  output logic [$clog2(SIZE):0]    count,
  output logic [$clog2(SIZE):0]    countNext,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PW = $clog2(SIZE);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  assign headNext  = r_head + PW'(pop);
  assign countNext = r_count + pushCount - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= headNext;
      r_tail  <= r_tail + pushCount[PW-1:0];
      r_count <= countNext;
    end
  end

  assign headPtr = r_head;
  assign tailPtr = r_tail;
  assign count   = r_count;
  assign full    = (r_count == CW'(SIZE));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/pht_update_queue.sv
// Coalescing queue of PHT counter updates: folds same-index updates, merges
// into queued entries, drains one write per cycle and counts dropped updates.
module pht_update_queue
  import FetchUnitTypes::*;
#(
  parameter int unsigned ENTRY_NUM   = PHT_UPDATE_QUEUE_SIZE,
  parameter int unsigned IN_WIDTH    = 2,
  parameter int unsigned INDEX_WIDTH = PHT_INDEX_WIDTH,
  parameter int unsigned CTR_WIDTH   = PHT_CTR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [IN_WIDTH-1:0]                   inValid,
  input  logic [IN_WIDTH-1:0][INDEX_WIDTH-1:0]  inIndex,
  input  logic [IN_WIDTH-1:0][CTR_WIDTH-1:0]    inPrevCtr,
  input  logic [IN_WIDTH-1:0]                   inTaken,
  output logic                                  wrValid,
  output logic [INDEX_WIDTH-1:0]                wrIndex,
  output logic [CTR_WIDTH-1:0]                  wrCtr,
  input  logic                                  wrReady,
  output logic [$clog2(ENTRY_NUM):0]            count,
  output logic [15:0]                           dropCount
);
  localparam int unsigned PW = $clog2(ENTRY_NUM);
  localparam int unsigned CW = PW + 1;
  localparam logic [7:0]  CTR_MAX = 8'((1 << CTR_WIDTH) - 1);

  logic [INDEX_WIDTH-1:0] r_idx     [ENTRY_NUM];
  logic [CTR_WIDTH-1:0]   r_ctr     [ENTRY_NUM];
  logic [INDEX_WIDTH-1:0] w_idxNext [ENTRY_NUM];
  logic [CTR_WIDTH-1:0]   w_ctrNext [ENTRY_NUM];

  logic                   r_wrValid;
  logic [INDEX_WIDTH-1:0] r_wrIndex;
  logic [CTR_WIDTH-1:0]   r_wrCtr;
  logic [15:0]            r_dropCount;

  logic [PW-1:0]  w_head, w_tail, w_headNext, w_hitSlot, w_off;
  logic [CW-1:0]  w_count, w_countNext, w_free, w_push;
  logic           w_full, w_empty, w_pop;
  logic [15:0]    w_drops;
  logic [16:0]    w_dropSum;

  logic [CTR_WIDTH-1:0] w_res  [IN_WIDTH];
  logic                 w_drop [IN_WIDTH];
  logic [PW-1:0]        w_slot [IN_WIDTH];
  logic [CTR_WIDTH-1:0] w_base;
  logic                 w_folded, w_hit, w_need;

  assign w_pop = r_wrValid && wrReady && !w_empty;

  QueuePointer #(.SIZE(ENTRY_NUM)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .pushCount (w_push),
    .pop       (w_pop),
    .headPtr   (w_head),
    .tailPtr   (w_tail),
    .headNext  (w_headNext),
    .count     (w_count),
    .countNext (w_countNext),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_idxNext = r_idx;
    w_ctrNext = r_ctr;
    w_push    = '0;
    w_drops   = '0;
    w_free    = w_full ? '0 : CW'(ENTRY_NUM) - w_count;
    w_base    = '0;
    w_folded  = 1'b0;
    w_hit     = 1'b0;
    w_need    = 1'b0;
    w_hitSlot = '0;
    w_off     = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      w_res[i]  = '0;
      w_drop[i] = 1'b0;
      w_slot[i] = '0;
    end
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (inValid[i]) begin
        w_folded = 1'b0;
        w_hit    = 1'b0;
        w_need   = 1'b0;
        w_base   = inPrevCtr[i];
        // The highest matching lower lane already carries the cumulative value.
        for (int unsigned j = 0; j < i; j++) begin
          if (inValid[j] && inIndex[j] == inIndex[i]) begin
            w_folded  = 1'b1;
            w_base    = w_res[j];
            w_drop[i] = w_drop[j];
            w_slot[i] = w_slot[j];
          end
        end
        if (!w_folded) begin
          for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
            w_off = PW'(k) - w_head;
            if ({1'b0, w_off} < w_count && r_idx[k] == inIndex[i]) begin
              w_hit     = 1'b1;
              w_hitSlot = PW'(k);
            end
          end
          if (w_hit) w_base = r_ctr[w_hitSlot];
          // A popping head cannot absorb the merge; its value forwards into a new entry.
          if (w_hit && !(w_pop && w_hitSlot == w_head)) w_slot[i] = w_hitSlot;
          else w_need = 1'b1;
          if (w_need) begin
            if (w_push < w_free) begin
              w_slot[i] = w_tail + w_push[PW-1:0];
              w_push    = w_push + CW'(1);
            end else begin
              w_drop[i] = 1'b1;
            end
          end
        end
        w_res[i] = CTR_WIDTH'(step(8'(w_base), inTaken[i], CTR_MAX));
        if (w_drop[i]) begin
          w_drops = w_drops + 16'd1;
        end else begin
          w_idxNext[w_slot[i]] = inIndex[i];
          w_ctrNext[w_slot[i]] = w_res[i];
        end
      end
    end
    w_dropSum = {1'b0, r_dropCount} + {1'b0, w_drops};
  end

  always_ff @(posedge clk) begin
    r_idx <= w_idxNext;
    r_ctr <= w_ctrNext;
  end

  // Head outputs are registered from next-state so nothing combinational reaches wr*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrValid   <= 1'b0;
      r_wrIndex   <= '0;
      r_wrCtr     <= '0;
      r_dropCount <= '0;
    end else begin
      r_wrValid   <= (w_countNext != '0);
      r_wrIndex   <= (w_countNext != '0) ? w_idxNext[w_headNext] : '0;
      r_wrCtr     <= (w_countNext != '0) ? w_ctrNext[w_headNext] : '0;
      r_dropCount <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    end
  end

  assign wrValid   = r_wrValid;
  assign wrIndex   = r_wrIndex;
  assign wrCtr     = r_wrCtr;
  assign count     = w_count;
  assign dropCount = r_dropCount;

endmodule

// File: tb/tb_pht_update_queue.sv
// Randomized and directed bench for pht_update_queue against a queue-based model.
module tb_pht_update_queue;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       inValid = '0;
  logic [1:0][9:0]  inIndex = '0;
  logic [1:0][1:0]  inPrevCtr = '0;
  logic [1:0]       inTaken = '0;
  logic             wrValid;
  logic [9:0]       wrIndex;
  logic [1:0]       wrCtr;
  logic             wrReady = 1'b0;
  logic [3:0]       count;
  logic [15:0]      dropCount;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    int unsigned idx;
    int unsigned ctr;
  } ent_t;

  ent_t        m_q[$];
  int unsigned m_drop = 0;

  pht_update_queue #(
    .ENTRY_NUM   (8),
    .IN_WIDTH    (2),
    .INDEX_WIDTH (10),
    .CTR_WIDTH   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inIndex   (inIndex),
    .inPrevCtr (inPrevCtr),
    .inTaken   (inTaken),
    .wrValid   (wrValid),
    .wrIndex   (wrIndex),
    .wrCtr     (wrCtr),
    .wrReady   (wrReady),
    .count     (count),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_step(input int unsigned c, input bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic check_outputs();
    check_val("wrValid", 32'(wrValid), 32'(m_q.size() != 0));
    check_val("count", 32'(count), 32'(m_q.size()));
    check_val("dropCount", 32'(dropCount), m_drop);
    if (m_q.size() != 0) begin
      check_val("wrIndex", 32'(wrIndex), m_q[0].idx);
      check_val("wrCtr", 32'(wrCtr), m_q[0].ctr);
    end
  endtask

  // Next model state from the current inputs and the pre-edge model state.
  task automatic model_update();
    ent_t        wq[$];
    ent_t        head;
    ent_t        e;
    bit          pop;
    int unsigned free_slots, used, base;
    int unsigned res[2];
    bit          dropped[2];
    bit          folded, need;
    int          pos;
    pop = (m_q.size() != 0) && wrReady;
    wq = m_q;
    head.idx = 0;
    head.ctr = 0;
    if (pop) head = wq.pop_front();
    free_slots = 8 - m_q.size();
    used = 0;
    for (int i = 0; i < 2; i++) begin
      dropped[i] = 1'b0;
      res[i] = 0;
      if (!inValid[i]) continue;
      folded = 1'b0;
      need = 1'b0;
      pos = -1;
      base = 32'(inPrevCtr[i]);
      for (int j = 0; j < i; j++) begin
        if (inValid[j] && inIndex[j] == inIndex[i]) begin
          folded = 1'b1;
          base = res[j];
          dropped[i] = dropped[j];
        end
      end
      for (int k = 0; k < wq.size(); k++)
        if (wq[k].idx == 32'(inIndex[i])) pos = k;
      if (!folded) begin
        if (pos >= 0) base = wq[pos].ctr;
        else if (pop && head.idx == 32'(inIndex[i])) begin base = head.ctr; need = 1'b1; end
        else need = 1'b1;
      end
      res[i] = ref_step(base, inTaken[i]);
      if (need) begin
        if (used < free_slots) begin
          e.idx = 32'(inIndex[i]);
          e.ctr = res[i];
          wq.push_back(e);
          used++;
        end else begin
          dropped[i] = 1'b1;
        end
      end else if (!dropped[i] && pos >= 0) begin
        wq[pos].ctr = res[i];
      end
      if (dropped[i] && m_drop < 65535) m_drop++;
    end
    m_q = wq;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    inValid = '0;
  endtask

  task automatic set_lane(input int l, input int unsigned idx, input int unsigned prev, input bit t);
    inValid[l]   = 1'b1;
    inIndex[l]   = 10'(idx);
    inPrevCtr[l] = 2'(prev);
    inTaken[l]   = t;
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check_val("rst_wrIndex", 32'(wrIndex), 0);
    check_val("rst_wrCtr", 32'(wrCtr), 0);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Single update and drain
    wrReady = 1'b0;
    set_lane(0, 'h05, 1, 1'b1);
    tick();
    check_val("basic_valid", 32'(wrValid), 1);
    check_val("basic_index", 32'(wrIndex), 'h05);
    check_val("basic_ctr", 32'(wrCtr), 2);
    check_val("basic_count", 32'(count), 1);
    idle();
    wrReady = 1'b1;
    tick();
    check_val("basic_drained", 32'(count), 0);

    // Saturation at both ends
    set_lane(0, 'h06, 3, 1'b1);
    tick();
    check_val("sat_hi", 32'(wrCtr), 3);
    idle();
    set_lane(0, 'h07, 0, 1'b0);
    tick();
    check_val("sat_lo", 32'(wrCtr), 0);
    idle();
    tick();

    // Same-cycle fold
    set_lane(0, 'h10, 1, 1'b1);
    set_lane(1, 'h10, 1, 1'b1);
    tick();
    check_val("fold_count", 32'(count), 1);
    check_val("fold_ctr", 32'(wrCtr), 3);
    idle();
    tick();

    // Merge into a queued entry
    wrReady = 1'b0;
    set_lane(0, 'h20, 2, 1'b0);
    tick();
    check_val("merge_first", 32'(wrCtr), 1);
    set_lane(0, 'h20, 3, 1'b0);
    tick();
    check_val("merge_ctr", 32'(wrCtr), 0);
    check_val("merge_count", 32'(count), 1);
    idle();
    wrReady = 1'b1;
    tick();
    tick();

    // Overflow
    wrReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 'h40 + 2 * c, 0, 1'b1);
      set_lane(1, 'h41 + 2 * c, 0, 1'b1);
      tick();
    end
    set_lane(0, 'h48, 0, 1'b1);
    set_lane(1, 'h49, 0, 1'b1);
    tick();
    check_val("ovf_count", 32'(count), 8);
    check_val("ovf_drop", 32'(dropCount), 2);
    idle();
    wrReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check_val("ovf_order", 32'(wrIndex), 'h40 + c);
      tick();
    end
    check_val("ovf_empty", 32'(count), 0);

    // Randomized traffic with alternating ready pressure
    for (int c = 0; c < 2000; c++) begin
      for (int l = 0; l < 2; l++)
        set_lane(l, $urandom_range(0, 11), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      inValid = 2'($urandom_range(0, 3));
      wrReady = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end

    // Asynchronous reset while draining
    idle();
    wrReady = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    wrReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 'h100 + 2 * c, 1, 1'b1);
      set_lane(1, 'h101 + 2 * c, 1, 1'b0);
      tick();
    end
    idle();
    wrReady = 1'b1;
    tick();
    check_val("arst_pre_count", 32'(count), 5);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(wrValid), 0);
    check_val("arst_count", 32'(count), 0);
    check_val("arst_drop", 32'(dropCount), 0);
    m_q.delete();
    m_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    for (int c = 0; c < 50; c++) begin
      for (int l = 0; l < 2; l++)
        set_lane(l, $urandom_range(0, 11), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      inValid = 2'($urandom_range(0, 3));
      wrReady = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
